nt_node_pipe_p: RTL

Parametrised, lane-vectored successor of the single-bit Nt-node capture subcircuit used in the trojan-detection benchmark set.
- Each of WIDTH lanes evaluates the same node function: a NAND term against a DEPTH-stage delayed input, combined under a selectable mode with a gated registered term. The result lands in an output register.
- Adds features the single-bit cell lacks: valid-qualified advance, mode select, a priming indicator and a saturating all-ones hit counter for rare-event (trigger) monitoring.

---
 rtl/nt_node_pipe_p.sv | 61 ++++++
 1 files changed

// File: rtl/nt_node_pipe_p.sv
// nt_node_pipe_p: lane-vectored Nt-node capture with delay line, mode select, priming flag and saturating hit counter
module nt_node_pipe_p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             I1294,
  input  logic             I1301,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] e0,
  input  logic [WIDTH-1:0] e1,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             out_primed,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             hit_sat
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [WIDTH-1:0] dline [DEPTH];
  logic [WIDTH-1:0] c_q, t_nand, t_and, res;
  logic [FW-1:0]    fill, fill_nxt;
  logic [CNT_W-1:0] hit_nxt;
  logic             upd;
  always_comb begin
    t_nand   = ~(~a & dline[DEPTH-1]);
    t_and    = c_q & ~(e0 | e1);
    res      = mode[1] ? (t_nand ^ t_and) : mode[0] ? (t_nand & t_and) : (t_nand | t_and);
    upd      = in_vld && mode != 2'b11;
    fill_nxt = (fill == FULL) ? fill : fill + FW'(1);
    hit_nxt  = (upd && &res && !(&hit_cnt)) ? hit_cnt + CNT_W'(1) : hit_cnt;
  end
  always_ff @(posedge I1294) begin
    if (I1301) begin
      for (int k = 0; k < DEPTH; k++) dline[k] <= '0;
      c_q        <= '0;
      fill       <= '0;
      out        <= '0;
      out_vld    <= 1'b0;
      out_primed <= 1'b0;
      hit_cnt    <= '0;
      hit_sat    <= 1'b0;
    end else begin
      out_vld <= upd;
      if (in_vld) begin
        dline[0] <= d;
        for (int k = 1; k < DEPTH; k++) dline[k] <= dline[k-1];
        c_q        <= c;
        fill       <= fill_nxt;
        out_primed <= out_primed | (fill_nxt == FULL);
        hit_cnt    <= hit_nxt;
        hit_sat    <= hit_sat | (&hit_nxt);
        if (upd) out <= res;
      end
    end
  end
endmodule
